// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_t      : loader FSM states
//   SYNC_BYTE    : frame start marker
//   ACK_OK/ERR   : acknowledge bytes returned to the host
//   ERR_*        : err_code values
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_ACK
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_OK    = 8'h4B;
    localparam logic [7:0] ACK_ERR   = 8'h45;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, acknowledge and instruction-RAM write signals of the loader.
//   rx_data/rx_valid : byte from the UART receiver (one-cycle strobe)
//   tx_data/tx_valid : acknowledge byte to the UART transmitter
//   tx_ready         : transmitter accepts tx_data when tx_valid=1
//   wr_en/addr/data  : instruction RAM write port
// slave  : the loader side
// master : the UART / RAM environment side
interface imem_loader_if #(
    parameter int ADDR_W = 8
) ();

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid, wr_en, wr_addr, wr_data
    );

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/imem_loader_timeout.sv
// Inter-byte timeout timer (down-counter with terminal-count compare).
//   clk, rst_n : clock, async active-low reset
//   clear      : reload the full timeout window (a byte arrived)
//   enable     : count down while the loader is inside a frame
//   expire     : window used up with no byte; only meaningful while enabled
module loader_timeout #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Loaded with TIMEOUT_CYC-1 on each byte, so expiry is seen
    // TIMEOUT_CYC-1 cycles later and acted on at the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = enable && (cnt == '0);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: frames a UART byte stream
// (A5, LEN_HI, LEN_LO, N*4 big-endian data bytes, CSUM), writes the words
// into the instruction RAM and acknowledges with 0x4B (ok) or 0x45 (error).
//   clk, rst_n : clock, async active-low reset
//   bus        : rx byte stream, tx acknowledge, RAM write port
//   cpu_hold   : CPU held in reset while high
//   busy       : FSM not idle
//   done       : one-cycle pulse when a successful load is acknowledged
//   err        : sticky error flag, cleared by the next accepted sync byte
//   err_code   : 0 none, 1 bad length, 2 checksum, 3 timeout
//
// state    | meaning
// ---------+---------------------------------------------------
// S_IDLE   | waiting for sync byte, other bytes ignored
// S_LEN_HI | waiting for upper length byte
// S_LEN_LO | waiting for lower length byte, range check
// S_DATA   | collecting data bytes, one RAM write per 4 bytes
// S_CSUM   | waiting for checksum byte
// S_ACK    | acknowledge byte pending until tx_ready
module imem_loader
    import loader_pkg::*;
#(
    parameter int ROM_SIZE      = 256,
    parameter int ADDR_W        = 8,
    parameter int TIMEOUT_CYC   = 1000000,
    parameter bit HOLD_AT_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [15:0] MAX_LEN = 16'(ROM_SIZE);

    state_t      state;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [7:0]  csum;
    logic [23:0] shift;
    logic        tmr_en;
    logic        tmr_expire;
    logic [15:0] len_rx;

    assign len_rx = {len_hi, bus.rx_data};
    assign tmr_en = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CSUM);
    assign busy   = (state != S_IDLE);

    loader_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (bus.rx_valid),
        .enable (tmr_en),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            len_hi       <= '0;
            len          <= '0;
            word_idx     <= '0;
            byte_cnt     <= '0;
            csum         <= '0;
            shift        <= '0;
            bus.tx_data  <= '0;
            bus.tx_valid <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            cpu_hold     <= HOLD_AT_RESET;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
        end else begin
            bus.wr_en <= 1'b0;
            done      <= 1'b0;
            // A byte arriving on the expiry cycle takes priority.
            if (tmr_expire && !bus.rx_valid) begin
                err          <= 1'b1;
                err_code     <= ERR_TIMEOUT;
                bus.tx_data  <= ACK_ERR;
                bus.tx_valid <= 1'b1;
                state        <= S_ACK;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                            state    <= S_LEN_HI;
                            cpu_hold <= 1'b1;
                            err      <= 1'b0;
                            err_code <= ERR_NONE;
                            word_idx <= '0;
                            byte_cnt <= '0;
                            csum     <= '0;
                        end
                    end
                    S_LEN_HI: begin
                        if (bus.rx_valid) begin
                            len_hi <= bus.rx_data;
                            state  <= S_LEN_LO;
                        end
                    end
                    S_LEN_LO: begin
                        if (bus.rx_valid) begin
                            len <= len_rx;
                            if ((len_rx == 16'd0) || (len_rx > MAX_LEN)) begin
                                err          <= 1'b1;
                                err_code     <= ERR_LEN;
                                bus.tx_data  <= ACK_ERR;
                                bus.tx_valid <= 1'b1;
                                state        <= S_ACK;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (bus.rx_valid) begin
                            csum     <= csum + bus.rx_data;
                            shift    <= {shift[15:0], bus.rx_data};
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                bus.wr_en   <= 1'b1;
                                bus.wr_addr <= word_idx[ADDR_W-1:0];
                                bus.wr_data <= {shift, bus.rx_data};
                                word_idx    <= word_idx + 16'd1;
                                if (word_idx == (len - 16'd1)) begin
                                    state <= S_CSUM;
                                end
                            end
                        end
                    end
                    S_CSUM: begin
                        if (bus.rx_valid) begin
                            bus.tx_valid <= 1'b1;
                            state        <= S_ACK;
                            if (bus.rx_data == csum) begin
                                bus.tx_data <= ACK_OK;
                            end else begin
                                err         <= 1'b1;
                                err_code    <= ERR_CSUM;
                                bus.tx_data <= ACK_ERR;
                            end
                        end
                    end
                    S_ACK: begin
                        if (bus.tx_ready) begin
                            bus.tx_valid <= 1'b0;
                            state        <= S_IDLE;
                            // Failed loads keep the CPU held.
                            if (!err) begin
                                cpu_hold <= 1'b0;
                                done     <= 1'b1;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (TIMEOUT_CYC = 100).
module tb_imem_loader;
    import loader_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_hold, busy, done, err;
    logic [1:0] err_code;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(8)) bus ();

    imem_loader #(
        .ROM_SIZE      (256),
        .ADDR_W        (8),
        .TIMEOUT_CYC   (100),
        .HOLD_AT_RESET (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    logic [7:0]  frm   [0:11] = '{8'h08, 8'h00, 8'h00, 8'h03, 8'h3C, 8'h04,
                                  8'h40, 8'h00, 8'h20, 8'h09, 8'h00, 8'h01};
    logic [31:0] exp_w [0:2]  = '{32'h08000003, 32'h3C044000, 32'h20090001};

    // Write / done observer (outputs only, sampled on the falling edge).
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [7:0]  wa [0:63];
    logic [31:0] wd [0:63];

    always @(negedge clk) begin
        if (bus.wr_en) begin
            if (wr_cnt < 64) begin
                wa[wr_cnt] = bus.wr_addr;
                wd[wr_cnt] = bus.wr_data;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic accept_ack;
        @(negedge clk);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_reset;
        #22;
        n_chk++;
        if ({bus.tx_data, bus.tx_valid, bus.wr_en, bus.wr_addr, bus.wr_data,
             cpu_hold, busy, done, err, err_code} !== 56'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got tx=%h tv=%b we=%b wa=%h wd=%h hold=%b busy=%b done=%b err=%b code=%0d, want all zero",
                     bus.tx_data, bus.tx_valid, bus.wr_en, bus.wr_addr, bus.wr_data,
                     cpu_hold, busy, done, err, err_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load;
        int bw, bd;
        bw = wr_cnt;
        bd = done_cnt;
        send_byte(8'hA5);
        n_chk++;
        if ({cpu_hold, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL load_sync: got hold=%b busy=%b want 1 1", cpu_hold, busy);
        end
        send_byte(8'h00);
        send_byte(8'h03);
        for (int i = 0; i < 12; i++) begin
            send_byte(frm[i]);
            if (i == 3) begin
                n_chk++;
                if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 8'h00, 32'h08000003}) begin
                    n_fail++;
                    $display("FAIL load_wr_latency: got we=%b wa=%h wd=%h want 1 00 08000003",
                             bus.wr_en, bus.wr_addr, bus.wr_data);
                end
            end
        end
        send_byte(8'hB5);
        n_chk++;
        if ({bus.tx_valid, bus.tx_data} !== {1'b1, ACK_OK}) begin
            n_fail++;
            $display("FAIL load_ack: got tv=%b tx=%h want 1 4b", bus.tx_valid, bus.tx_data);
        end
        n_chk++;
        if (wr_cnt - bw !== 3) begin
            n_fail++;
            $display("FAIL load_wr_count: got %0d want 3", wr_cnt - bw);
        end
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if ({wa[bw+k], wd[bw+k]} !== {8'(k), exp_w[k]}) begin
                n_fail++;
                $display("FAIL load_word%0d: got %h/%h want %h/%h", k, wa[bw+k], wd[bw+k], 8'(k), exp_w[k]);
            end
        end
        accept_ack;
        n_chk++;
        if ({done, cpu_hold, bus.tx_valid, busy, err} !== 5'b10000) begin
            n_fail++;
            $display("FAIL load_done: got done=%b hold=%b tv=%b busy=%b err=%b want 1 0 0 0 0",
                     done, cpu_hold, bus.tx_valid, busy, err);
        end
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if ({done, done_cnt - bd} !== {1'b0, 32'd1}) begin
            n_fail++;
            $display("FAIL load_done_pulse: got done=%b pulses=%0d want 0 1", done, done_cnt - bd);
        end
    endtask

    task automatic test_csum_err;
        int bw, bd;
        bw = wr_cnt;
        bd = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h03);
        for (int i = 0; i < 12; i++) send_byte(frm[i]);
        send_byte(8'hB6);
        n_chk++;
        if ({bus.tx_valid, bus.tx_data, err, err_code} !== {1'b1, ACK_ERR, 1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL csum_ack: got tv=%b tx=%h err=%b code=%0d want 1 45 1 2",
                     bus.tx_valid, bus.tx_data, err, err_code);
        end
        n_chk++;
        if (wr_cnt - bw !== 3) begin
            n_fail++;
            $display("FAIL csum_wr_count: got %0d want 3", wr_cnt - bw);
        end
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if ({wa[bw+k], wd[bw+k]} !== {8'(k), exp_w[k]}) begin
                n_fail++;
                $display("FAIL csum_word%0d: got %h/%h want %h/%h", k, wa[bw+k], wd[bw+k], 8'(k), exp_w[k]);
            end
        end
        accept_ack;
        @(negedge clk);
        n_chk++;
        if ({cpu_hold, busy, err, err_code, done_cnt - bd} !== {1'b1, 1'b0, 1'b1, 2'd2, 32'd0}) begin
            n_fail++;
            $display("FAIL csum_after: got hold=%b busy=%b err=%b code=%0d pulses=%0d want 1 0 1 2 0",
                     cpu_hold, busy, err, err_code, done_cnt - bd);
        end
    endtask

    task automatic test_bad_len;
        logic [15:0] lens [0:1] = '{16'h0101, 16'h0000};
        int bw;
        for (int c = 0; c < 2; c++) begin
            bw = wr_cnt;
            send_byte(8'hA5);
            send_byte(lens[c][15:8]);
            send_byte(lens[c][7:0]);
            n_chk++;
            if ({bus.tx_valid, bus.tx_data, err, err_code} !== {1'b1, ACK_ERR, 1'b1, 2'd1}) begin
                n_fail++;
                $display("FAIL badlen_%h: got tv=%b tx=%h err=%b code=%0d want 1 45 1 1",
                         lens[c], bus.tx_valid, bus.tx_data, err, err_code);
            end
            accept_ack;
            @(negedge clk);
            n_chk++;
            if ({busy, wr_cnt - bw} !== {1'b0, 32'd0}) begin
                n_fail++;
                $display("FAIL badlen_%h_nowrite: got busy=%b writes=%0d want 0 0", lens[c], busy, wr_cnt - bw);
            end
        end
    endtask

    task automatic test_timeout;
        int bw;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h08);
        repeat (99) @(negedge clk);
        n_chk++;
        if ({err, bus.tx_valid, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL timeout_early: at cycle 99 got err=%b tv=%b busy=%b want 0 0 1", err, bus.tx_valid, busy);
        end
        @(negedge clk);
        n_chk++;
        if ({err, err_code, bus.tx_valid, bus.tx_data} !== {1'b1, 2'd3, 1'b1, ACK_ERR}) begin
            n_fail++;
            $display("FAIL timeout_fire: at cycle 100 got err=%b code=%0d tv=%b tx=%h want 1 3 1 45",
                     err, err_code, bus.tx_valid, bus.tx_data);
        end
        accept_ack;
        n_chk++;
        if ({cpu_hold, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL timeout_hold: got hold=%b busy=%b want 1 0", cpu_hold, busy);
        end
        // Byte landing on the expiry cycle must win.
        bw = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h08);
        repeat (98) @(negedge clk);
        send_byte(8'h00);
        n_chk++;
        if ({err, bus.tx_valid, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL timeout_byte_wins: got err=%b tv=%b busy=%b want 0 0 1", err, bus.tx_valid, busy);
        end
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h0B);
        n_chk++;
        if ({bus.tx_valid, bus.tx_data, wr_cnt - bw, wd[bw]} !== {1'b1, ACK_OK, 32'd1, 32'h08000003}) begin
            n_fail++;
            $display("FAIL timeout_resume: got tv=%b tx=%h writes=%0d wd=%h want 1 4b 1 08000003",
                     bus.tx_valid, bus.tx_data, wr_cnt - bw, wd[bw]);
        end
        accept_ack;
        n_chk++;
        if ({done, cpu_hold} !== 2'b10) begin
            n_fail++;
            $display("FAIL timeout_resume_done: got done=%b hold=%b want 1 0", done, cpu_hold);
        end
    endtask

    task automatic test_garbage;
        logic [7:0] g [0:2] = '{8'h00, 8'hFF, 8'h5A};
        int bw;
        bw = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            send_byte(g[i]);
            n_chk++;
            if ({busy, bus.tx_valid, cpu_hold, err, wr_cnt - bw} !== {4'b0000, 32'd0}) begin
                n_fail++;
                $display("FAIL garbage_%h: got busy=%b tv=%b hold=%b err=%b writes=%0d want 0 0 0 0 0",
                         g[i], busy, bus.tx_valid, cpu_hold, err, wr_cnt - bw);
            end
        end
    endtask

    task automatic test_ack_stall;
        int bw, bd;
        bw = wr_cnt;
        bd = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        send_byte(8'h38);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 10) begin
                bus.rx_data  = 8'hA5;
                bus.rx_valid = 1'b1;
            end else begin
                bus.rx_valid = 1'b0;
            end
            n_chk++;
            if ({bus.tx_valid, bus.tx_data, busy} !== {1'b1, ACK_OK, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: got tv=%b tx=%h busy=%b want 1 4b 1", i, bus.tx_valid, bus.tx_data, busy);
            end
        end
        n_chk++;
        if ({wr_cnt - bw, wa[bw], wd[bw]} !== {32'd1, 8'h00, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL stall_write: got writes=%0d %h/%h want 1 00/deadbeef", wr_cnt - bw, wa[bw], wd[bw]);
        end
        accept_ack;
        n_chk++;
        if ({bus.tx_valid, done, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL stall_accept: got tv=%b done=%b busy=%b want 0 1 0", bus.tx_valid, done, busy);
        end
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if ({bus.tx_valid, done, done_cnt - bd} !== {2'b00, 32'd1}) begin
            n_fail++;
            $display("FAIL stall_single: got tv=%b done=%b pulses=%0d want 0 0 1", bus.tx_valid, done, done_cnt - bd);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d [0:8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        int bw;
        bw = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        n_chk++;
        if ({bus.tx_valid, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL len256_accepted: got tv=%b busy=%b want 0 1", bus.tx_valid, busy);
        end
        for (int i = 0; i < 9; i++) send_byte(d[i]);
        n_chk++;
        if ({wr_cnt - bw, wa[bw+1], wd[bw+1]} !== {32'd2, 8'h01, 32'h55667788}) begin
            n_fail++;
            $display("FAIL midframe_writes: got writes=%0d %h/%h want 2 01/55667788", wr_cnt - bw, wa[bw+1], wd[bw+1]);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({bus.tx_data, bus.tx_valid, bus.wr_en, bus.wr_addr, bus.wr_data,
             cpu_hold, busy, done, err, err_code} !== 56'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got tx=%h tv=%b we=%b wa=%h wd=%h hold=%b busy=%b done=%b err=%b code=%0d, want all zero",
                     bus.tx_data, bus.tx_valid, bus.wr_en, bus.wr_addr, bus.wr_data,
                     cpu_hold, busy, done, err, err_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bw = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        send_byte(8'h38);
        n_chk++;
        if ({bus.tx_valid, bus.tx_data, wr_cnt - bw, wa[bw], wd[bw]} !== {1'b1, ACK_OK, 32'd1, 8'h00, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL postreset_frame: got tv=%b tx=%h writes=%0d %h/%h want 1 4b 1 00/deadbeef",
                     bus.tx_valid, bus.tx_data, wr_cnt - bw, wa[bw], wd[bw]);
        end
        accept_ack;
        n_chk++;
        if ({done, cpu_hold, err} !== 3'b100) begin
            n_fail++;
            $display("FAIL postreset_done: got done=%b hold=%b err=%b want 1 0 0", done, cpu_hold, err);
        end
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        test_reset;
        test_load;
        test_csum_err;
        test_bad_len;
        test_timeout;
        test_garbage;
        test_ack_stall;
        test_reset_mid;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction-memory writer that pairs with the CPU's read-only instruction store.
- Takes a byte stream from the UART receiver, frames it, and assembles big-endian 32-bit instruction words.
- Writes the words sequentially into the instruction RAM write port while holding the CPU in reset.
- Reports success or failure back to the host through the UART transmitter handshake.

Parameters:
- ROM_SIZE, 256, instruction memory depth in words; maximum accepted word count.
- ADDR_W, 8, word-address width; must satisfy 2**ADDR_W >= ROM_SIZE.
- TIMEOUT_CYC, 1000000, idle clock cycles allowed between bytes inside a frame.
- HOLD_AT_RESET, 0, reset value of cpu_hold.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle.
- tx_data  out  8  acknowledge byte to the UART transmitter.
- tx_valid  out  1  acknowledge byte pending.
- tx_ready  in  1  transmitter accepts tx_data at a rising edge when tx_valid=1.
- wr_en  out  1  instruction RAM write strobe, one cycle per word.
- wr_addr  out  ADDR_W  word index, starting at 0.
- wr_data  out  32  assembled instruction word.
- cpu_hold  out  1  holds the CPU in reset while high.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after a successful load is acknowledged.
- err  out  1  sticky error flag.
- err_code  out  2  0 none, 1 bad length, 2 checksum, 3 timeout.

Behaviour:
- Frame format: SYNC 0xA5, LEN_HI, LEN_LO, then N*4 data bytes (big-endian, word = {b0,b1,b2,b3}), then CSUM.
  - CSUM = 8-bit sum mod 256 of the data bytes only.
- Reset values: tx_data=0, tx_valid=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=HOLD_AT_RESET, busy=0, done=0, err=0, err_code=0.
  - Internal state: state=IDLE, byte counter 0, word counter 0, checksum accumulator 0, timeout counter 0.
  - Instruction RAM contents are never touched by reset.
- States and transitions: IDLE, LEN_HI, LEN_LO, DATA, CSUM, ACK.
  - IDLE: bytes other than 0xA5 are ignored. On 0xA5: go to LEN_HI, cpu_hold<=1, err<=0, err_code<=0, clear counters and checksum.
  - LEN_HI -> LEN_LO: latch the upper length byte.
  - LEN_LO: latch N. If N==0 or N>ROM_SIZE, set err=1, err_code=1, go to ACK with tx_data=0x45, no writes. Otherwise go to DATA.
  - DATA: each byte is added to the checksum and shifted into the word register.
    - On the 4th byte of a word: in the next cycle wr_en=1 for exactly one cycle, wr_addr = word index, wr_data = word.
    - The word index increments after the write.
    - After word N-1 is written, go to CSUM.
  - CSUM: if the byte equals the accumulator, queue 0x4B; otherwise err=1, err_code=2, queue 0x45. Go to ACK.
    - On a checksum error, words already written are not rolled back.
  - ACK: tx_valid=1 with tx_data stable until a rising edge with tx_ready=1. Then tx_valid<=0 and state<=IDLE.
    - On success: cpu_hold<=0 and done=1 for one cycle, both in the same edge.
    - On error: cpu_hold stays 1 until a later successful load.
- Timeout: the counter clears on every rx_valid and runs in LEN_HI, LEN_LO, DATA and CSUM.
  - When it reaches TIMEOUT_CYC-1 with no byte: err=1, err_code=3, queue 0x45, go to ACK.
  - If rx_valid and expiry coincide in the same cycle, the byte wins and the timeout does not fire.
- rx_valid in ACK is ignored, including 0xA5.
- Latency: wr_en asserts 1 cycle after the rx_valid of the word's last byte. tx_valid asserts 1 cycle after the rx_valid of CSUM.
- Reset asserted mid-frame: all outputs return to reset values immediately. The next frame restarts at wr_addr 0.
- err and err_code are sticky until the next 0xA5 is accepted in IDLE.

Decomposition:
- Shared package loader_pkg:
  - state enum.
  - SYNC_BYTE=8'hA5, ACK_OK=8'h4B, ACK_ERR=8'h45.
  - ERR_NONE/ERR_LEN/ERR_CSUM/ERR_TIMEOUT codes.
- One sub-module, loader_timeout: loadable cycle counter with clear, enable and expire outputs.

Test Plan:
- Load 3 words: send A5 00 03 08 00 00 03 3C 04 40 00 20 09 00 01 B5.
  - Required: writes (0,0x08000003), (1,0x3C044000), (2,0x20090001).
  - Then tx 0x4B, done pulse, cpu_hold=0, err=0.
- Same frame with CSUM 0xB6.
  - Required: three writes still occur, tx 0x45, err=1, err_code=2, cpu_hold stays 1, no done.
- Bad length: A5 01 01 (257), then separately A5 00 00.
  - Required: each gives no wr_en, tx 0x45, err_code=1.
- Timeout with TIMEOUT_CYC=100: send A5 00 01 08, then silence.
  - Required: exactly 100 cycles after the last rx_valid, err_code=3 and tx 0x45.
  - A byte arriving on the expiry cycle prevents the timeout.
- Garbage bytes 00 FF 5A in IDLE.
  - Required: busy stays 0, no state change.
- During ACK, hold tx_ready low for 50 cycles.
  - Required: tx_valid=1 and tx_data constant throughout; single accept when tx_ready rises.
- Assert rst_n=0 mid-DATA.
  - Required: all outputs at reset values at once; a fresh frame then writes from addr 0.
